// File: rtl/muxdc_pkg.sv
// Shared types and default widths for the mux dataflow controller.
package muxdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int LENGTHBUS_DEF           = 8;
  localparam int BITWIDTH_W_COLUMS_DEF   = 4;
  localparam int BITWIDTH_MAX_W_SIZE_DEF = 9;

endpackage

// File: rtl/muxdc_fsm.sv
// Sequencer: walks the bus one mux per cycle and flags kernel-row boundaries.
// Drives clear/write strobes for the select register; owns the done level.
module muxdc_fsm
  import muxdc_pkg::*;
#(
  parameter int LENGTHBUS           = LENGTHBUS_DEF,
  parameter int BITWIDTH_W_COLUMS   = BITWIDTH_W_COLUMS_DEF,
  parameter int BITWIDTH_MAX_W_SIZE = BITWIDTH_MAX_W_SIZE_DEF,
  localparam int IDXW               = $clog2(LENGTHBUS) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           set_conf,
  input  logic                           conf_ok,
  input  logic [BITWIDTH_W_COLUMS-1:0]   w_colums,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0] w_roxcl,
  output logic                           sel_clr,
  output logic                           sel_wr,
  output logic                           sel_bit,
  output logic [IDXW-1:0]                idx,
  output logic                           conf_done
);

  state_t                         state, state_nxt;
  logic [IDXW-1:0]                idx_nxt;
  logic [BITWIDTH_W_COLUMS-1:0]   col, col_nxt;
  logic [BITWIDTH_W_COLUMS-1:0]   wc_r, wc_nxt;
  logic [BITWIDTH_MAX_W_SIZE-1:0] wr_r, wr_nxt;
  logic                           done_nxt;
  logic [BITWIDTH_W_COLUMS-1:0]   wc_last;
  logic                           last_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      col       <= '0;
      wc_r      <= '0;
      wr_r      <= '0;
      conf_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      col       <= col_nxt;
      wc_r      <= wc_nxt;
      wr_r      <= wr_nxt;
      conf_done <= done_nxt;
    end
  end

  // wc_r==0 never matches, so the subtraction below cannot produce a false boundary.
  assign wc_last  = wc_r - BITWIDTH_W_COLUMS'(1);
  assign last_col = (wc_r != '0) && (col == wc_last);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    col_nxt   = col;
    wc_nxt    = wc_r;
    wr_nxt    = wr_r;
    done_nxt  = conf_done;
    sel_clr   = 1'b0;
    sel_wr    = 1'b0;
    sel_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (set_conf) begin
          wc_nxt    = w_colums;
          wr_nxt    = w_roxcl;
          idx_nxt   = '0;
          col_nxt   = '0;
          sel_clr   = 1'b1;
          state_nxt = CONFIG;
        end
      end
      CONFIG: begin
        sel_wr  = 1'b1;
        sel_bit = last_col && (32'(idx) < 32'(wr_r));
        col_nxt = last_col ? '0 : col + BITWIDTH_W_COLUMS'(1);
        idx_nxt = idx + IDXW'(1);
        if (idx == IDXW'(LENGTHBUS - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      DONE: begin
        if (conf_ok) begin
          done_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/muxdc.sv
// Mux dataflow controller top: builds the bus mux select vector one bit per cycle
// after a configuration request, then holds it and raises a level done flag until acked.
module muxdc
  import muxdc_pkg::*;
#(
  parameter int LENGTHBUS           = LENGTHBUS_DEF,
  parameter int BITWIDTH_W_COLUMS   = BITWIDTH_W_COLUMS_DEF,
  parameter int BITWIDTH_MAX_W_SIZE = BITWIDTH_MAX_W_SIZE_DEF
) (
  input  logic                           MUXDC_Clk,
  input  logic                           MUXDC_Reset,
  input  logic                           MUXDC_Set_Conf,
  input  logic                           MUXDC_Set_Conf_Already_Ok,
  input  logic [BITWIDTH_W_COLUMS-1:0]   MUXDC_W_Colums,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0] MUXDC_W_ROXCL,
  output logic [LENGTHBUS-1:0]           MUXDC_Muxes_Sel,
  output logic                           MUXDC_Set_Conf_Already
);

  localparam int IDXW = $clog2(LENGTHBUS) + 1;

  logic                 sel_clr, sel_wr, sel_bit;
  logic [IDXW-1:0]      idx;
  logic [LENGTHBUS-1:0] sel_r, sel_nxt;

  muxdc_fsm #(
    .LENGTHBUS           (LENGTHBUS),
    .BITWIDTH_W_COLUMS   (BITWIDTH_W_COLUMS),
    .BITWIDTH_MAX_W_SIZE (BITWIDTH_MAX_W_SIZE)
  ) u_fsm (
    .clk       (MUXDC_Clk),
    .rst       (MUXDC_Reset),
    .set_conf  (MUXDC_Set_Conf),
    .conf_ok   (MUXDC_Set_Conf_Already_Ok),
    .w_colums  (MUXDC_W_Colums),
    .w_roxcl   (MUXDC_W_ROXCL),
    .sel_clr   (sel_clr),
    .sel_wr    (sel_wr),
    .sel_bit   (sel_bit),
    .idx       (idx),
    .conf_done (MUXDC_Set_Conf_Already)
  );

  always_comb begin
    sel_nxt = sel_r;
    if (sel_clr) begin
      sel_nxt = '0;
    end else if (sel_wr) begin
      for (int i = 0; i < LENGTHBUS; i++) begin
        if (idx == IDXW'(i)) sel_nxt[i] = sel_bit;
      end
    end
  end

  always_ff @(posedge MUXDC_Clk or posedge MUXDC_Reset) begin
    if (MUXDC_Reset) sel_r <= '0;
    else             sel_r <= sel_nxt;
  end

  assign MUXDC_Muxes_Sel = sel_r;

endmodule

// File: tb/tb_muxdc.sv
// Bench for muxdc: randomized configurations scored against a queue of expected
// select vectors and done-flag arrival edges computed from the boundary rule.
module tb_muxdc;
  localparam int LB  = 8;
  localparam int WCW = 4;
  localparam int WSW = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           set_conf;
  logic           conf_ok;
  logic [WCW-1:0] wc;
  logic [WSW-1:0] wr;
  logic [LB-1:0]  sel;
  logic           done;

  always #5 clk = ~clk;

  muxdc #(
    .LENGTHBUS           (LB),
    .BITWIDTH_W_COLUMS   (WCW),
    .BITWIDTH_MAX_W_SIZE (WSW)
  ) dut (
    .MUXDC_Clk                 (clk),
    .MUXDC_Reset               (rst),
    .MUXDC_Set_Conf            (set_conf),
    .MUXDC_Set_Conf_Already_Ok (conf_ok),
    .MUXDC_W_Colums            (wc),
    .MUXDC_W_ROXCL             (wr),
    .MUXDC_Muxes_Sel           (sel),
    .MUXDC_Set_Conf_Already    (done)
  );

  typedef struct {
    logic [LB-1:0] vec;
    int            rise;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edges = 0;

  always @(posedge clk) edges <= edges + 1;

  // A mux closes a kernel row when its 1-based position is a multiple of the
  // column count, provided it lies inside the rows*cols-1 window.
  function automatic logic [LB-1:0] model(int c, int r);
    logic [LB-1:0] v;
    v = '0;
    for (int i = 0; i < LB; i++)
      if (c > 0 && ((i + 1) % c) == 0 && i < r) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: scores each done-flag rise, then checks the vector holds.
  logic          prev_done = 1'b0;
  logic          have = 1'b0;
  logic [LB-1:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
      have      = 1'b0;
    end else begin
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sel_vec", 32'(sel), 32'(e.vec));
          chk("done_latency", 32'(edges), 32'(e.rise));
          held = e.vec;
          have = 1'b1;
        end
      end else if (have && exp_q.size() == 0) begin
        chk("sel_hold", 32'(sel), 32'(held));
      end
      prev_done = done;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic run_conf(int c, int r, bit repulse, int ack_delay);
    exp_t e;
    @(negedge clk);
    wc = WCW'(c);
    wr = WSW'(r);
    set_conf = 1'b1;
    e.vec  = model(c, r);
    e.rise = edges + 9;
    exp_q.push_back(e);
    @(negedge clk);
    set_conf = 1'b0;
    wc = WCW'($urandom);
    wr = WSW'($urandom);
    if (repulse) begin
      repeat (2) @(negedge clk);
      set_conf = 1'b1;
      conf_ok  = 1'b1;
      @(negedge clk);
      set_conf = 1'b0;
      conf_ok  = 1'b0;
    end
    wait_done();
    if (repulse) begin
      set_conf = 1'b1;
      @(negedge clk);
      set_conf = 1'b0;
    end
    repeat (ack_delay) @(negedge clk);
    conf_ok = 1'b1;
    @(negedge clk);
    conf_ok = 1'b0;
    chk("done_clear", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    chk("done_stays_low", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; set_conf = 1'b0; conf_ok = 1'b0; wc = '0; wr = '0;
    #1;
    chk("reset_sel", 32'(sel), 32'h00);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    wc = 4'd1; wr = 9'd8; set_conf = 1'b1;
    repeat (3) @(negedge clk);
    set_conf = 1'b0;
    chk("reset_sel_pulsed", 32'(sel), 32'h00);
    chk("reset_done_pulsed", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_sel", 32'(sel), 32'h00);
    chk("idle_done", 32'(done), 32'd0);

    run_conf(3, 8, 1'b0, 2);   // expected 8'h24
    run_conf(2, 3, 1'b0, 0);   // expected 8'h02
    run_conf(1, 8, 1'b0, 1);   // expected 8'hFF
    run_conf(0, 8, 1'b0, 1);   // expected 8'h00
    run_conf(3, 8, 1'b1, 3);   // re-pulses ignored
    run_conf(3, 300, 1'b0, 0); // window wider than bus
    run_conf(1, 3, 1'b0, 0);   // expected 8'h07

    for (int k = 0; k < 24; k++)
      run_conf($urandom_range(0, 15), $urandom_range(0, 511),
               1'($urandom_range(0, 1)), $urandom_range(0, 4));

    // Reset mid-CONFIG after three bits are already written.
    @(negedge clk);
    wc = 4'd1; wr = 9'd8; set_conf = 1'b1;
    e.vec = 8'hFF; e.rise = edges + 9;
    exp_q.push_back(e);
    @(negedge clk);
    set_conf = 1'b0;
    repeat (3) @(negedge clk);
    chk("partial_sel", 32'(sel), 32'h07);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_sel", 32'(sel), 32'h00);
    chk("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_conf(3, 8, 1'b0, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
